// File: rtl/dcache_wbuf.sv
// DCache write buffer: FIFO of line evictions and uncached stores drained
// one at a time to the AXI bridge, with a refill read-hazard check.
module dcache_wbuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           in_wr_req,
    input  logic [2:0]     in_wr_type,
    input  logic [31:0]    in_wr_addr,
    input  logic [3:0]     in_wr_wstrb,
    input  logic [127:0]   in_wr_data,
    output logic           in_wr_rdy,
    output logic           out_wr_req,
    output logic [2:0]     out_wr_type,
    output logic [31:0]    out_wr_addr,
    output logic [3:0]     out_wr_wstrb,
    output logic [127:0]   out_wr_data,
    input  logic           out_wr_rdy,
    input  logic           out_wr_done,
    input  logic [31:0]    chk_addr,
    output logic           chk_hit,
    output logic           wb_empty,
    output logic [PTR_W:0] wb_count
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] WAIT_B = 1'b1;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [2:0]       type_q  [DEPTH];
    logic [31:0]      addr_q  [DEPTH];
    logic [3:0]       wstrb_q [DEPTH];
    logic [127:0]     data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [0:0]       state;

    logic push;
    logic pop;
    logic issue;
    logic unused_chk;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign in_wr_rdy  = (count != FULL);
    assign push       = in_wr_req & in_wr_rdy;
    assign out_wr_req = (state == IDLE) & (count != '0);
    assign issue      = out_wr_req & out_wr_rdy;
    assign pop        = (state == WAIT_B) & out_wr_done;

    assign out_wr_type  = type_q[head];
    assign out_wr_addr  = addr_q[head];
    assign out_wr_wstrb = wstrb_q[head];
    assign out_wr_data  = data_q[head];

    assign wb_empty   = (count == '0) & (state == IDLE);
    assign wb_count   = count;
    assign unused_chk = ^chk_addr[3:0];

    always_comb begin
        valid_d = valid_q;
        if (pop)
            valid_d[head] = 1'b0;
        if (push)
            valid_d[tail] = 1'b1;
    end

    // The in-flight head stays valid until its B response, so it still hits.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:4] == chk_addr[31:4]))
                chk_hit = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            case (state)
                IDLE:    if (issue) state <= WAIT_B;
                WAIT_B:  if (out_wr_done) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            type_q[tail]  <= in_wr_type;
            addr_q[tail]  <= in_wr_addr;
            wstrb_q[tail] <= in_wr_wstrb;
            data_q[tail]  <= in_wr_data;
        end
    end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Bench for dcache_wbuf: directed scenarios plus random traffic checked
// against a queue-based model of the write buffer.
module tb_dcache_wbuf;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         in_wr_req;
    logic [2:0]   in_wr_type;
    logic [31:0]  in_wr_addr;
    logic [3:0]   in_wr_wstrb;
    logic [127:0] in_wr_data;
    logic         in_wr_rdy;
    logic         out_wr_req;
    logic [2:0]   out_wr_type;
    logic [31:0]  out_wr_addr;
    logic [3:0]   out_wr_wstrb;
    logic [127:0] out_wr_data;
    logic         out_wr_rdy;
    logic         out_wr_done;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         wb_empty;
    logic [2:0]   wb_count;

    dcache_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_wr_req(in_wr_req), .in_wr_type(in_wr_type),
        .in_wr_addr(in_wr_addr), .in_wr_wstrb(in_wr_wstrb),
        .in_wr_data(in_wr_data), .in_wr_rdy(in_wr_rdy),
        .out_wr_req(out_wr_req), .out_wr_type(out_wr_type),
        .out_wr_addr(out_wr_addr), .out_wr_wstrb(out_wr_wstrb),
        .out_wr_data(out_wr_data), .out_wr_rdy(out_wr_rdy),
        .out_wr_done(out_wr_done), .chk_addr(chk_addr),
        .chk_hit(chk_hit), .wb_empty(wb_empty), .wb_count(wb_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [2:0]   t;
        logic [31:0]  a;
        logic [3:0]   s;
        logic [127:0] d;
    } ent_t;

    ent_t q[$];
    bit   infl;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic hit;
        #1;
        hit = 1'b0;
        foreach (q[i])
            if (q[i].a[31:4] == chk_addr[31:4]) hit = 1'b1;
        chk("rdy", in_wr_rdy, q.size() != 4);
        chk("req", out_wr_req, !infl && q.size() > 0);
        chk("count", wb_count, q.size());
        chk("empty", wb_empty, q.size() == 0 && !infl);
        chk("hit", chk_hit, hit);
        if (q.size() > 0) begin
            chk("type", out_wr_type, q[0].t);
            chk("addr", out_wr_addr, q[0].a);
            chk("wstrb", out_wr_wstrb, q[0].s);
            chk("data", out_wr_data, q[0].d);
        end
    endtask

    // One clock edge: the model advances from the inputs seen before the edge.
    task automatic cyc();
        bit   push, acc, pop;
        ent_t e, x;
        push = in_wr_req && q.size() < 4;
        acc  = !infl && q.size() > 0 && out_wr_rdy;
        pop  = infl && out_wr_done;
        e = '{in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data};
        @(posedge aclk);
        #1;
        if (pop) begin
            x = q.pop_front();
            infl = 0;
        end else if (acc) begin
            infl = 1;
        end
        if (push) q.push_back(e);
        check_all();
    endtask

    task automatic set_push(input logic [2:0] t, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d);
        in_wr_req   = 1'b1;
        in_wr_type  = t;
        in_wr_addr  = a;
        in_wr_wstrb = s;
        in_wr_data  = d;
    endtask

    task automatic drain();
        in_wr_req = 1'b0;
        for (int i = 0; i < 40 && !(q.size() == 0 && !infl); i++) begin
            out_wr_rdy  = 1'b1;
            out_wr_done = infl;
            cyc();
        end
        out_wr_done = 1'b0;
        chk("drain_empty", wb_empty, 1'b1);
    endtask

    localparam logic [127:0] LINE =
        128'h0123456789abcdef_fedcba9876543210;

    initial begin
        logic [31:0] aset [4];
        aset[0] = 32'h1c000040;
        aset[1] = 32'h1c000044;
        aset[2] = 32'h00000100;
        aset[3] = 32'h80001230;

        aresetn = 1'b0;
        in_wr_req = 1'b0; in_wr_type = '0; in_wr_addr = '0;
        in_wr_wstrb = '0; in_wr_data = '0;
        out_wr_rdy = 1'b0; out_wr_done = 1'b0; chk_addr = '0;
        infl = 0;
        repeat (2) @(posedge aclk);
        #2;
        chk("rst_req", out_wr_req, 1'b0);
        chk("rst_rdy", in_wr_rdy, 1'b1);
        chk("rst_empty", wb_empty, 1'b1);
        chk("rst_hit", chk_hit, 1'b0);
        chk("rst_count", wb_count, 3'd0);
        aresetn = 1'b1;

        // single push and hazard check on the line
        out_wr_rdy = 1'b1;
        chk_addr = 32'h1c00004c;
        set_push(3'b100, 32'h1c000040, 4'hf, LINE);
        cyc();
        in_wr_req = 1'b0;
        chk("sp_req", out_wr_req, 1'b1);
        chk("sp_addr", out_wr_addr, 32'h1c000040);
        chk("sp_data", out_wr_data, LINE);
        chk("hz_hit", chk_hit, 1'b1);
        chk_addr = 32'h1c000050;
        #1;
        chk("hz_miss", chk_hit, 1'b0);
        chk_addr = 32'h1c00004c;
        cyc();
        chk("sp_waitb_req", out_wr_req, 1'b0);
        repeat (4) cyc();
        chk("hz_inflight", chk_hit, 1'b1);
        out_wr_done = 1'b1;
        cyc();
        out_wr_done = 1'b0;
        chk("sp_count", wb_count, 3'd0);
        chk("sp_empty", wb_empty, 1'b1);
        chk("hz_clear", chk_hit, 1'b0);

        // done in IDLE is ignored
        out_wr_rdy = 1'b0;
        set_push(3'b010, 32'h00000020, 4'h3, 128'h55);
        cyc();
        in_wr_req = 1'b0;
        out_wr_done = 1'b1;
        cyc();
        out_wr_done = 1'b0;
        chk("spur_count", wb_count, 3'd1);
        chk("spur_req", out_wr_req, 1'b1);
        drain();

        // fill to full, reject a fifth, drain in order
        out_wr_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_push(3'b100, 32'h100 * i, 4'hf, {4{$urandom}});
            cyc();
        end
        in_wr_req = 1'b0;
        chk("full_rdy", in_wr_rdy, 1'b0);
        chk("full_count", wb_count, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("order", out_wr_addr, 32'h100 * i);
            out_wr_rdy = 1'b1;
            cyc();
            out_wr_rdy = 1'b0;
            cyc();
            out_wr_done = 1'b1;
            cyc();
            out_wr_done = 1'b0;
        end
        chk("fill_empty", wb_empty, 1'b1);

        // push coincident with pop
        set_push(3'b100, 32'h0a0, 4'hf, 128'h1);
        cyc();
        set_push(3'b100, 32'h0b0, 4'hf, 128'h2);
        out_wr_rdy = 1'b1;
        cyc();
        out_wr_rdy = 1'b0;
        set_push(3'b100, 32'h0c0, 4'hf, 128'h3);
        out_wr_done = 1'b1;
        cyc();
        in_wr_req = 1'b0;
        out_wr_done = 1'b0;
        chk("sim_count", wb_count, 3'd2);
        chk("sim_next", out_wr_addr, 32'h0b0);
        drain();

        // random traffic, many pointer wraps
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1)
                set_push(3'($urandom_range(0, 4)),
                         aset[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 16),
                         4'($urandom), {$urandom, $urandom, $urandom, $urandom});
            else
                in_wr_req = 1'b0;
            out_wr_rdy  = ($urandom_range(0, 2) != 0);
            out_wr_done = ($urandom_range(0, 2) == 0);
            chk_addr    = aset[$urandom_range(0, 3)] + 32'($urandom_range(0, 7) * 8);
            cyc();
        end
        out_wr_done = 1'b0;
        drain();

        // reset while a write is in flight with three entries queued
        out_wr_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(3'b100, 32'h1c000040 + 32'(i * 16), 4'hf, LINE);
            cyc();
        end
        in_wr_req = 1'b0;
        out_wr_rdy = 1'b1;
        cyc();
        out_wr_rdy = 1'b0;
        chk_addr = 32'h1c000040;
        cyc();
        chk("pre_rst_count", wb_count, 3'd3);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_req", out_wr_req, 1'b0);
        chk("mid_rst_rdy", in_wr_rdy, 1'b1);
        chk("mid_rst_empty", wb_empty, 1'b1);
        chk("mid_rst_hit", chk_hit, 1'b0);
        chk("mid_rst_count", wb_count, 3'd0);
        q.delete();
        infl = 0;
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        out_wr_rdy = 1'b1;
        set_push(3'b100, 32'h1c000040, 4'hf, LINE);
        cyc();
        in_wr_req = 1'b0;
        chk("post_rst_req", out_wr_req, 1'b1);
        chk("post_rst_addr", out_wr_addr, 32'h1c000040);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_wbuf.md
Name: dcache_wbuf

Overview:
- Write buffer between the DCache write-back port and the AXI bridge's DCache write interface.
- Queues dirty-line evictions and uncached stores in a small FIFO, so the DCache can refill without waiting for the AXI B response.
- Drains entries one at a time to the bridge.
- Provides a read-hazard check so the DCache does not issue a refill read for a line still held in the buffer.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- in_wr_req  in  1  DCache write request.
- in_wr_type  in  3  3'b100 = 16-byte line burst; 3'b0xx = single beat, size given by [1:0].
- in_wr_addr  in  32  write address.
- in_wr_wstrb  in  4  byte strobe for a single beat; 4'hf for a line.
- in_wr_data  in  128  line data; beat 0 = [31:0].
- in_wr_rdy  out  1  buffer can accept; equals ~full.
- out_wr_req  out  1  request to the bridge.
- out_wr_type  out  3  type of the head entry.
- out_wr_addr  out  32  address of the head entry.
- out_wr_wstrb  out  4  strobe of the head entry.
- out_wr_data  out  128  data of the head entry.
- out_wr_rdy  in  1  bridge accepts; transfer occurs when out_wr_req & out_wr_rdy.
- out_wr_done  in  1  one-cycle pulse from the bridge on B handshake (bvalid & bready).
- chk_addr  in  32  DCache read-miss address to check.
- chk_hit  out  1  chk_addr[31:4] equals the [31:4] address of any valid entry.
- wb_empty  out  1  FIFO empty and drain FSM in IDLE; used for fence/ibar ordering.
- wb_count  out  PTR_W+1  number of valid entries.

Behaviour:
- Storage: DEPTH entries of {type, addr, wstrb, data}, plus a per-entry valid bit. Head pointer and tail pointer are PTR_W bits and wrap modulo DEPTH. count runs 0..DEPTH.
- Push: on in_wr_req & in_wr_rdy, the entry is written at tail, its valid bit is set, and tail increments. in_wr_rdy = (count != DEPTH). A pop in the same cycle does not make room for that cycle's push.
- Head outputs: out_wr_type/addr/wstrb/data are driven combinationally from entry[head]. They are held stable until the pop.
- Drain FSM, two states:
  - IDLE: out_wr_req = (count != 0). On out_wr_req & out_wr_rdy, go to WAIT_B.
  - WAIT_B: out_wr_req = 0. On out_wr_done, pop (clear valid[head], head+1, count-1) and go to IDLE.
  - The head entry stays valid, and visible to chk_hit, until its B response.
- out_wr_done in IDLE is ignored: no pop, no state change.
- Latency:
  - An entry pushed at edge k drives out_wr_req high in the cycle after edge k when the FIFO was empty and the FSM was in IDLE.
  - The next entry's out_wr_req is asserted in the cycle after the out_wr_done edge.
  - At most one outstanding write to the bridge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Ordering: strict FIFO; no merging or coalescing of writes to the same line.
- chk_hit: purely combinational OR over all valid entries; includes the in-flight head. The DCache stalls its refill request while chk_hit = 1.
- wb_empty = (count == 0) & (state == IDLE).
- Reset, asynchronous, may occur mid-operation:
  - Values: state = IDLE, head = tail = 0, count = 0, all valid bits = 0, out_wr_req = 0, in_wr_rdy = 1, chk_hit = 0, wb_empty = 1.
  - Pending and in-flight entries are discarded.
  - Entry data and address registers need not be reset.

Test Plan:
- Single push: push a line, type 3'b100, addr 0x1c000040, data 128'h0123…; out_wr_rdy = 1 → out_wr_req is high in the next cycle with identical fields. FSM enters WAIT_B and out_wr_req drops. A done pulse 5 cycles later → count 0, wb_empty 1.
- Fill and full: hold out_wr_rdy = 0 and push 4 entries (addr 0x100, 0x200, 0x300, 0x400) → in_wr_rdy = 0 with count 4. A 5th request is not accepted. Release → drains in order 0x100 → 0x400, one per done pulse.
- Simultaneous push/pop: with count = 2, assert a push in the same cycle as out_wr_done → count stays 2 and the next out_wr_addr is the second entry. Exercise pointer wrap by pushing 9 entries total.
- Hazard: buffer holds 0x1c000040 → chk_addr 0x1c00004c gives chk_hit = 1; 0x1c000050 gives 0. While that entry is in WAIT_B, chk_hit stays 1 until the cycle after out_wr_done.
- Spurious done: pulse out_wr_done in IDLE with count = 1 → no pop, count stays 1, out_wr_req stays 1.
- Reset mid-drain: deassert aresetn while in WAIT_B with count = 3 → outputs immediately take reset values (out_wr_req 0, in_wr_rdy 1, wb_empty 1, chk_hit 0). After release, the first push behaves like the single-push case.
